// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: sequences MEM-stage loads/stores and round-robins the single data-memory port with a DMA/debug requester.
// Optional wait timeout with bus error pulse is compiled in when MEM_TIMEOUT_EN is defined.

package data_mem_arbiter_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef enum logic [2:0] {
    IDLE,
    CORE_WAIT,
    CORE_DONE,
    DMA_WAIT,
    DMA_DONE
  } state_t;
endpackage

module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req_valid,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        dma_req_valid,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ready,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state_q, state_d;
  logic              last_dma_q, last_dma_d;
  logic              mem_en_q, mem_en_d;
  mem_req_t          req_q, req_d;
  mem_req_t          core_req, dma_req;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              dma_ready_q, dma_ready_d;
  logic              grant_core, grant_dma;
  logic              timeout;

  assign core_req = '{we: core_we, addr: core_addr, wdata: core_wdata};
  assign dma_req  = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};

  // Round-robin: on contention the requester that did not win last time goes first.
  assign grant_core = core_req_valid && (!dma_req_valid || last_dma_q);
  assign grant_dma  = dma_req_valid && !grant_core;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_dma_d   = last_dma_q;
    mem_en_d     = mem_en_q;
    req_d        = req_q;
    core_rdata_d = core_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    dma_ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_core) begin
          mem_en_d   = 1'b1;
          req_d      = core_req;
          last_dma_d = 1'b0;
          state_d    = CORE_WAIT;
        end else if (grant_dma) begin
          mem_en_d   = 1'b1;
          req_d      = dma_req;
          last_dma_d = 1'b1;
          state_d    = DMA_WAIT;
        end
      end
      CORE_WAIT, DMA_WAIT: begin
        // An ack arriving in the timeout cycle completes normally.
        if (mem_ack || timeout) begin
          mem_en_d = 1'b0;
          req_d.we = 1'b0;
          if (state_q == CORE_WAIT) begin
            state_d = CORE_DONE;
            if (!mem_ack) begin
              core_rdata_d = TIMEOUT_DATA;
            end else if (!req_q.we) begin
              core_rdata_d = mem_rdata;
            end
          end else begin
            state_d     = DMA_DONE;
            dma_ready_d = 1'b1;
            if (!mem_ack) begin
              dma_rdata_d = TIMEOUT_DATA;
            end else if (!req_q.we) begin
              dma_rdata_d = mem_rdata;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_dma_q   <= 1'b1;
      mem_en_q     <= 1'b0;
      req_q        <= '0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
      dma_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_dma_q   <= last_dma_d;
      mem_en_q     <= mem_en_d;
      req_q        <= req_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_ready_q  <= dma_ready_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             bus_err_q;
  logic             in_wait;

  assign in_wait = (state_q == CORE_WAIT) || (state_q == DMA_WAIT);
  assign timeout = in_wait && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter is zero whenever a WAIT state is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_err_q <= timeout && !mem_ack;
      if (!in_wait) begin
        wait_cnt_q <= '0;
      end else if (!mem_ack) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign mem_en     = mem_en_q;
  assign mem_we     = req_q.we;
  assign mem_addr   = req_q.addr;
  assign mem_wdata  = req_q.wdata;
  assign core_rdata = core_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign dma_ready  = dma_ready_q;
  assign core_stall = core_req_valid && (state_q != CORE_DONE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 1 << 30;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req_valid, core_we, core_stall;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        dma_req_valid, dma_we, dma_ready;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_en, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req_valid(dma_req_valid), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model: 0 = port free, 1 = access outstanding, 2 = completion cycle.
  int          m_phase = 0;
  bit          own_core, last_dma = 1'b1;
  int          wcnt, lat, next_lat = 0;
  bit          end_ack, end_to, exp_core_done, exp_dma_ready, exp_bus_err, spur_en;
  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [31:0] exp_core_rdata = '0, exp_dma_rdata = '0;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic new_core();
    core_we    = 1'($urandom_range(0, 1));
    core_addr  = {24'h0, 4'($urandom_range(0, 15)), 4'h0};
    core_wdata = $urandom;
  endtask

  task automatic new_dma();
    dma_we    = 1'($urandom_range(0, 1));
    dma_addr  = {24'h0, 4'($urandom_range(0, 15)), 4'h0};
    dma_wdata = $urandom;
  endtask

  // One clock: advance the model, compare every output, then play the memory for this cycle.
  task automatic step();
    bit          pc, pd;
    logic        cw, dw;
    logic [31:0] ca, cdat, da, ddat;
    pc = core_req_valid; pd = dma_req_valid;
    cw = core_we; ca = core_addr; cdat = core_wdata;
    dw = dma_we;  da = dma_addr;  ddat = dma_wdata;
    @(posedge clk); #1;
    exp_core_done = 0; exp_dma_ready = 0; exp_bus_err = 0;
    case (m_phase)
      0: if (pc || pd) begin
        own_core = (pc && pd) ? last_dma : pc;
        last_dma = !own_core;
        {r_we, r_addr, r_wdata} = own_core ? {cw, ca, cdat} : {dw, da, ddat};
        lat = (next_lat < 0) ? int'($urandom_range(0, 6)) : next_lat;
        wcnt = 0;
        m_phase = 1;
      end
      1: if (end_ack || end_to) begin
        m_phase = 2;
        exp_core_done = own_core;
        exp_dma_ready = !own_core;
        exp_bus_err = end_to;
      end else begin
        wcnt++;
      end
      default: m_phase = 0;
    endcase

    chk("mem_en", mem_en, m_phase == 1);
    if (m_phase == 1) begin
      chk("mem_we", mem_we, r_we);
      chk("mem_addr", mem_addr, r_addr);
      chk("mem_wdata", mem_wdata, r_wdata);
    end else begin
      chk("mem_we_off", mem_we, 0);
    end
    chk("dma_ready", dma_ready, exp_dma_ready);
    chk("bus_err", bus_err, exp_bus_err);
    chk("core_rdata", core_rdata, exp_core_rdata);
    chk("dma_rdata", dma_rdata, exp_dma_rdata);
    chk("core_stall", core_stall, core_req_valid && !exp_core_done);

    end_ack = 0; end_to = 0; mem_ack = 0; mem_rdata = $urandom;
    if (m_phase == 1) begin
      if (wcnt == lat && lat < TO) begin
        mem_ack = 1; end_ack = 1;
        if (r_we) mem[r_addr] = r_wdata;
        else begin
          mem_rdata = mem_rd(r_addr);
          if (own_core) exp_core_rdata = mem_rdata; else exp_dma_rdata = mem_rdata;
        end
      end else if (wcnt == TO - 1) begin
        end_to = 1;
        if (own_core) exp_core_rdata = 32'hDEAD_BEEF; else exp_dma_rdata = 32'hDEAD_BEEF;
      end
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      mem_ack = 1;
    end
  endtask

  // Pulse reset mid-cycle and check every output against its reset value.
  task automatic apply_reset();
    reset = 0; mem_ack = 0;
    #2;
    m_phase = 0; last_dma = 1; end_ack = 0; end_to = 0;
    exp_core_rdata = '0; exp_dma_rdata = '0;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_dma_ready", dma_ready, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_core_stall", core_stall, core_req_valid);
    #2;
    reset = 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_phase != 0; i++) step();
    step();
  endtask

  // Single core access from an idle port; exp_en is the expected number of mem_en cycles.
  task automatic core_access(input string tag, input logic we, input logic [31:0] a, input logic [31:0] d,
                             input int l, input int exp_en, input logic [31:0] exp_rd, input int exp_err);
    int k, en_cnt, err_cnt;
    core_req_valid = 1; core_we = we; core_addr = a; core_wdata = d; next_lat = l;
    k = 0; en_cnt = 0; err_cnt = 0;
    do begin
      step();
      k++;
      en_cnt += int'(mem_en);
      err_cnt += int'(bus_err);
    end while (core_stall && k < 64);
    chk({tag, "_stall_cycles"}, k, exp_en + 1);
    chk({tag, "_mem_en_cycles"}, en_cnt, exp_en);
    chk({tag, "_bus_err_pulses"}, err_cnt, exp_err);
    chk({tag, "_rdata"}, core_rdata, exp_rd);
    core_req_valid = 0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   done_n, pulses, k;
    bit   cdn, ddn, exp_core_next, got;
    logic [31:0] rd204;

    reset = 0; mem_ack = 0; mem_rdata = '0; spur_en = 0;
    core_req_valid = 1; core_we = 0; core_addr = '0; core_wdata = '0;
    dma_req_valid = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    @(posedge clk); #1;

    // Reset with a core request pending, then zero-wait load.
    apply_reset();
    mem[32'h100] = 32'hCAFE_F00D;
    core_access("t1_load", 0, 32'h100, 32'h0, 0, 1, 32'hCAFE_F00D, 0);

    // Store with three wait cycles leaves core_rdata alone.
    core_access("t2_store", 1, 32'h40, 32'h1234_5678, 3, 4, 32'hCAFE_F00D, 0);

    // Both requesters busy from reset: strict alternation starting with core.
    core_req_valid = 1; dma_req_valid = 1; new_core(); new_dma();
    apply_reset();
    next_lat = -1; exp_core_next = 1; done_n = 0;
    for (int c = 0; c < 200 && done_n < 6; c++) begin
      step();
      cdn = core_req_valid && !core_stall;
      ddn = dma_ready;
      if (cdn || ddn) begin
        chk("t3_order", {cdn, ddn}, exp_core_next ? 2'b10 : 2'b01);
        exp_core_next = !exp_core_next;
        done_n++;
        if (cdn) new_core();
        if (ddn) new_dma();
      end
    end
    chk("t3_done_count", done_n, 6);
    core_req_valid = 0; dma_req_valid = 0;
    drain();

    // Reset during a DMA read wait: access abandoned, core wins afterwards.
    dma_req_valid = 1; dma_we = 0; dma_addr = 32'h80; next_lat = 1000;
    step(); step();
    chk("t4_in_wait", mem_en, 1);
    core_req_valid = 1; new_core(); core_we = 0;
    apply_reset();
    next_lat = 0;
    step();
    chk("t4_core_first_addr", mem_addr, core_addr);
    k = 0;
    while (core_stall && k < 20) begin step(); k++; end
    core_req_valid = 0;
    got = 0; k = 0;
    while (!got && k < 20) begin step(); got = dma_ready; k++; end
    chk("t4_dma_completes", got, 1);
    dma_req_valid = 0;
    drain();

    // DMA drops valid mid-access: the write still lands and dma_ready fires once.
    dma_req_valid = 1; dma_we = 1; dma_addr = 32'hC0; dma_wdata = 32'h0BAD_F00D; next_lat = 2;
    step();
    dma_req_valid = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin step(); pulses += int'(dma_ready); end
    chk("t6_ready_pulses", pulses, 1);
    core_access("t6_readback", 0, 32'hC0, 32'h0, 1, 2, 32'h0BAD_F00D, 0);

    rd204 = mem_rd(32'h204);
`ifdef MEM_TIMEOUT_EN
    core_access("t5_timeout", 0, 32'h200, 32'h0, 1000, 4, 32'hDEAD_BEEF, 1);
    core_access("t5_ack_last", 0, 32'h204, 32'h0, 3, 4, rd204, 0);
`else
    core_access("t5_long_wait", 0, 32'h204, 32'h0, 9, 10, rd204, 0);
`endif

    // Randomized traffic with random latency and stray acks outside accesses.
    spur_en = 1; next_lat = -1;
    for (int c = 0; c < 1500; c++) begin
      step();
      if (core_req_valid && !core_stall) begin
        if ($urandom_range(0, 2) == 0) core_req_valid = 0; else new_core();
      end else if (!core_req_valid && $urandom_range(0, 3) == 0) begin
        core_req_valid = 1; new_core();
      end
      if (dma_req_valid && dma_ready) begin
        if ($urandom_range(0, 2) == 0) dma_req_valid = 0; else new_dma();
      end else if (!dma_req_valid && $urandom_range(0, 3) == 0) begin
        dma_req_valid = 1; new_dma();
      end
    end
    spur_en = 0; core_req_valid = 0; dma_req_valid = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
